// File: rtl/monitor_stat_streamer.sv
// Monitor statistics snapshot streamer.
// Captures the address/vector FIFO monitor histograms and counters on a host
// request or on the rising edge of end_program, then streams them as a
// 39-word valid/ready packet: header, sequence number, 36 data words, checksum.
module monitor_stat_streamer #(
  parameter logic [15:0] HEADER_WORD = 16'hA55A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              end_program,
  input  logic              snap_req,
  input  logic [15:0][15:0] addr_mon_cnts,
  input  logic [15:0][15:0] vctr_mon_cnts,
  input  logic [15:0]       addr_cycle_cnt,
  input  logic [15:0]       vctr_cycle_cnt,
  input  logic [15:0]       words_in_addr_fifo,
  input  logic [15:0]       words_in_vctr_fifo,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       snap_count,
  output logic              overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [5:0] LAST_IDX = 6'd38;

  state_t      r_state;
  state_t      w_next;
  logic        r_ep_prev;
  logic        w_trig;
  logic        w_accept;
  logic        w_capture;
  logic [15:0] r_snap [36];
  logic [5:0]  r_idx;
  logic [5:0]  w_bi;
  logic [15:0] r_csum;
  logic [15:0] r_snap_count;
  logic        r_overrun;
  logic [15:0] w_word;

  assign w_trig     = snap_req | (end_program & ~r_ep_prev);
  assign w_accept   = (r_state == SEND) & out_ready;
  assign w_capture  = (r_state == IDLE) & w_trig;
  assign w_bi       = r_idx - 6'd2;
  assign snap_count = r_snap_count;
  assign overrun    = r_overrun;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: capture on a trigger, return to IDLE once the checksum word is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_next = SEND;
      SEND:    if (w_accept && (r_idx == LAST_IDX)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Select the stream word for the current index
  always_comb begin
    w_word = '0;
    if (r_idx == 6'd0)          w_word = HEADER_WORD;
    else if (r_idx == 6'd1)     w_word = r_snap_count;
    else if (r_idx == LAST_IDX) w_word = r_csum;
    else if (r_idx < LAST_IDX)  w_word = r_snap[w_bi];
  end

  // Output decode: stream interface is driven only while sending
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (r_state == SEND) begin
      out_data  = w_word;
      out_valid = 1'b1;
      out_last  = (r_idx == LAST_IDX);
      busy      = 1'b1;
    end
  end

  // Snapshot capture, word index / checksum advance, counters and overrun flag.
  // The checksum accumulates each word as it is accepted, so it is complete by
  // the time the index reaches the checksum slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ep_prev    <= 1'b1;
      r_idx        <= '0;
      r_csum       <= '0;
      r_snap_count <= '0;
      r_overrun    <= 1'b0;
      for (int unsigned i = 0; i < 36; i++) r_snap[i] <= '0;
    end else begin
      r_ep_prev <= end_program;
      if (w_capture) begin
        for (int unsigned i = 0; i < 16; i++) begin
          r_snap[i]      <= addr_mon_cnts[i];
          r_snap[16 + i] <= vctr_mon_cnts[i];
        end
        r_snap[32] <= addr_cycle_cnt;
        r_snap[33] <= vctr_cycle_cnt;
        r_snap[34] <= words_in_addr_fifo;
        r_snap[35] <= words_in_vctr_fifo;
        if (r_snap_count != '1) r_snap_count <= r_snap_count + 16'd1;
        r_idx  <= '0;
        r_csum <= '0;
      end else if (w_accept && (r_idx != LAST_IDX)) begin
        r_idx  <= r_idx + 6'd1;
        r_csum <= r_csum + w_word;
      end
      if ((r_state == SEND) && w_trig) r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_monitor_stat_streamer.sv
// Randomised bench for monitor_stat_streamer with a queue-based reference
// model and literal checks of the directed stream contents.
module tb_monitor_stat_streamer;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              end_program = 1'b0;
  logic              snap_req = 1'b0;
  logic [15:0][15:0] addr_mon_cnts = '0;
  logic [15:0][15:0] vctr_mon_cnts = '0;
  logic [15:0]       addr_cycle_cnt = '0;
  logic [15:0]       vctr_cycle_cnt = '0;
  logic [15:0]       words_in_addr_fifo = '0;
  logic [15:0]       words_in_vctr_fifo = '0;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  logic [15:0]       snap_count;
  logic              overrun;

  monitor_stat_streamer #(.HEADER_WORD(16'hA55A)) dut (
    .clk(clk), .reset(reset), .end_program(end_program), .snap_req(snap_req),
    .addr_mon_cnts(addr_mon_cnts), .vctr_mon_cnts(vctr_mon_cnts),
    .addr_cycle_cnt(addr_cycle_cnt), .vctr_cycle_cnt(vctr_cycle_cnt),
    .words_in_addr_fifo(words_in_addr_fifo), .words_in_vctr_fifo(words_in_vctr_fifo),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .snap_count(snap_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] obs [$];
  int          lastcnt = 0;
  bit          rdy_rand = 1'b0;
  logic [15:0] lit [39];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q [$];
  logic [15:0] m_cnt = '0;
  logic        m_ovr = 1'b0;
  logic        m_prev = 1'b1;
  bit          m_en = 1'b0;

  always @(posedge clk) begin
    logic        trig;
    logic [15:0] sum;
    if (!reset) begin
      m_q.delete();
      m_cnt  = '0;
      m_ovr  = 1'b0;
      m_prev = 1'b1;
    end else begin
      trig   = snap_req || (end_program && !m_prev);
      m_prev = end_program;
      if (m_q.size() > 0) begin
        if (trig) m_ovr = 1'b1;
        if (out_ready) void'(m_q.pop_front());
      end else if (trig) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_q.push_back(16'hA55A);
        m_q.push_back(m_cnt);
        for (int i = 0; i < 16; i++) m_q.push_back(addr_mon_cnts[i]);
        for (int i = 0; i < 16; i++) m_q.push_back(vctr_mon_cnts[i]);
        m_q.push_back(addr_cycle_cnt);
        m_q.push_back(vctr_cycle_cnt);
        m_q.push_back(words_in_addr_fifo);
        m_q.push_back(words_in_vctr_fifo);
        sum = '0;
        for (int i = 0; i < m_q.size(); i++) sum = sum + m_q[i];
        m_q.push_back(sum);
      end
    end
    m_en = 1'b1;
  end

  // ---------------- per-cycle compare and observation ----------------
  always @(negedge clk) begin
    if (m_en) begin
      chk("out_valid",  {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      chk("busy",       {31'd0, busy},      {31'd0, m_q.size() > 0});
      chk("out_last",   {31'd0, out_last},  {31'd0, m_q.size() == 1});
      chk("out_data",   {16'd0, out_data},  {16'd0, (m_q.size() > 0) ? m_q[0] : 16'h0000});
      chk("snap_count", {16'd0, snap_count}, {16'd0, m_cnt});
      chk("overrun",    {31'd0, overrun},   {31'd0, m_ovr});
      if (out_valid && out_ready) begin
        obs.push_back(out_data);
        if (out_last) lastcnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_counters();
    for (int i = 0; i < 16; i++) begin
      addr_mon_cnts[i] = 16'($urandom);
      vctr_mon_cnts[i] = 16'($urandom);
    end
    addr_cycle_cnt     = 16'($urandom);
    vctr_cycle_cnt     = 16'($urandom);
    words_in_addr_fifo = 16'($urandom);
    words_in_vctr_fifo = 16'($urandom);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 16; i++) begin
      addr_mon_cnts[i] = 16'(i + 1);
      vctr_mon_cnts[i] = 16'h0100 + 16'(i);
    end
    addr_cycle_cnt     = 16'd5;
    vctr_cycle_cnt     = 16'd6;
    words_in_addr_fifo = 16'd7;
    words_in_vctr_fifo = 16'd8;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      rand_counters();
      snap_req    = 1'($urandom);
      end_program = 1'($urandom);
      out_ready   = 1'($urandom);
      @(posedge clk); #1;
    end
    reset       = 1'b1;
    snap_req    = 1'b0;
    end_program = 1'b0;
    out_ready   = 1'b1;
    obs.delete();
    lastcnt = 0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    rand_counters();
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_stream(input int maxc);
    for (int c = 0; c < maxc && obs.size() < 39; c++) step();
    chk("stream_len", obs.size(), 39);
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 40 && obs.size() < n; c++) step();
    chk("reach_word", {31'd0, obs.size() >= n}, 32'd1);
  endtask

  task automatic check_lit();
    chk("lit_len", obs.size(), 39);
    for (int i = 0; i < 39; i++)
      chk($sformatf("word%0d", i), {16'd0, (i < obs.size()) ? obs[i] : 16'hxxxx}, {16'd0, lit[i]});
    chk("last_count", lastcnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lit[0] = 16'hA55A;
    lit[1] = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      lit[2 + i]  = 16'(i + 1);
      lit[18 + i] = 16'h0100 + 16'(i);
    end
    lit[34] = 16'd5; lit[35] = 16'd6; lit[36] = 16'd7; lit[37] = 16'd8;
    lit[38] = 16'hB675;

    // Reset held with random inputs
    do_reset(3);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, snap_count}, 32'd0);
    chk("rst_data",  {16'd0, out_data}, 32'd0);

    // Directed snapshot, out_ready held high
    rdy_rand = 1'b0;
    set_pattern();
    pulse_snap();
    run_stream(60);
    check_lit();
    chk("count_1", {16'd0, snap_count}, 32'd1);
    // Trigger in the cycle right after the checksum is accepted
    obs.delete(); lastcnt = 0;
    pulse_snap();
    run_stream(60);
    chk("seq_2", {16'd0, (obs.size() > 1) ? obs[1] : 16'hxxxx}, 32'd2);
    chk("no_ovr_back2back", {31'd0, overrun}, 32'd0);

    // Same snapshot with random back-pressure
    do_reset(3);
    rdy_rand = 1'b1;
    set_pattern();
    pulse_snap();
    run_stream(400);
    check_lit();

    // Overrun: request during word 10
    do_reset(3);
    rdy_rand = 1'b0;
    set_pattern();
    pulse_snap();
    wait_words(10);
    pulse_snap();
    run_stream(60);
    for (int c = 0; c < 5; c++) step();
    check_lit();
    chk("ovr_set",   {31'd0, overrun}, 32'd1);
    chk("ovr_count", {16'd0, snap_count}, 32'd1);

    // Coincident snap_req and end_program edge, end_program then held high
    do_reset(3);
    @(posedge clk); #1;
    snap_req = 1'b1; end_program = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    for (int c = 0; c < 100; c++) step();
    end_program = 1'b0;
    chk("ep_len", obs.size(), 39);
    chk("ep_seq", {16'd0, (obs.size() > 1) ? obs[1] : 16'hxxxx}, 32'd1);
    chk("ep_ovr", {31'd0, overrun}, 32'd0);
    chk("ep_count", {16'd0, snap_count}, 32'd1);

    // Reset during word 10, then a fresh stream
    do_reset(3);
    set_pattern();
    pulse_snap();
    wait_words(10);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_count", {16'd0, snap_count}, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("abort_quiet", {31'd0, out_valid}, 32'd0);
    obs.delete(); lastcnt = 0;
    set_pattern();
    pulse_snap();
    run_stream(60);
    check_lit();

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_stat_streamer.md
MONITOR_STAT_STREAMER -- requirements
Module: monitor_stat_streamer

Interface
REQ-001 SHALL have parameter HEADER_WORD, default 16'hA55A: first word of every stream.
REQ-002 SHALL have port clk  input  1: rising-edge clock for all logic.
REQ-003 SHALL have port reset  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port end_program  input  1: program-end level; its rising edge triggers a snapshot.
REQ-005 SHALL have port snap_req  input  1: host snapshot request, sampled each cycle.
REQ-006 SHALL have port addr_mon_cnts  input  16x16: address-FIFO write-interval histogram bins 0..15.
REQ-007 SHALL have port vctr_mon_cnts  input  16x16: vector-FIFO write-interval histogram bins 0..15.
REQ-008 SHALL have ports addr_cycle_cnt, vctr_cycle_cnt, words_in_addr_fifo, words_in_vctr_fifo  input  16 each: monitor counters.
REQ-009 SHALL have port out_data  output  16: stream word.
REQ-010 SHALL have port out_valid  output  1: out_data valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the word.
REQ-012 SHALL have port out_last  output  1: marks the final (checksum) word.
REQ-013 SHALL have port busy  output  1: snapshot held or being streamed.
REQ-014 SHALL have port snap_count  output  16: snapshots captured since reset, saturating.
REQ-015 SHALL have port overrun  output  1: sticky; a trigger arrived while busy.

Function
REQ-016 SHALL use two states, IDLE and SEND; IDLE after reset.
REQ-017 Trigger SHALL be snap_req==1, or end_program==1 while its previous-cycle sample was 0; the previous-cycle sample register resets to 1.
REQ-018 In IDLE with a trigger at edge N, SHALL load all 36 input words into a snapshot buffer, increment snap_count (saturate at 16'hFFFF), clear the word index and checksum accumulator, and enter SEND.
REQ-019 Simultaneous snap_req and end_program edge SHALL produce exactly one capture.
REQ-020 out_valid SHALL be 1 and busy 1 from the cycle after N until the last word is accepted; stream latency is 1 cycle.
REQ-021 Stream order (39 words): HEADER_WORD; snap_count value after capture; addr_mon_cnts[0..15]; vctr_mon_cnts[0..15]; addr_cycle_cnt; vctr_cycle_cnt; words_in_addr_fifo; words_in_vctr_fifo; checksum.
REQ-022 Checksum SHALL be the modulo-2^16 sum of words 0..37; carries discarded.
REQ-023 Word SHALL advance only on out_valid && out_ready; otherwise out_data and out_last held stable.
REQ-024 Stream SHALL be fully determined by the snapshot; input changes after edge N SHALL NOT affect it.
REQ-025 out_last SHALL be 1 only while word 38 is presented.
REQ-026 On acceptance of word 38, out_valid, out_last and busy SHALL go 0 next cycle, state IDLE; a trigger in that next cycle SHALL be accepted.
REQ-027 A trigger in SEND, including the acceptance cycle of word 38, SHALL be dropped, set overrun=1 and leave snap_count unchanged; overrun clears only on reset.
REQ-028 With out_ready held 1, words SHALL issue on 39 consecutive cycles with no bubbles.

Reset
REQ-029 When reset==0 at a clock edge, next cycle SHALL have out_data=0, out_valid=0, out_last=0, busy=0, snap_count=0, overrun=0, state IDLE, snapshot buffer, index and checksum cleared.
REQ-030 Reset mid-stream SHALL abort the stream with no further words; no partial stream resumes.

Verification
REQ-031 Reset held 3 cycles with random inputs -> all outputs 0, no out_valid.
REQ-032 addr_mon_cnts[i]=i+1, vctr_mon_cnts[i]=16'h0100+i, addr_cycle_cnt=5, vctr_cycle_cnt=6, words_in_addr_fifo=7, words_in_vctr_fifo=8, one-cycle snap_req, out_ready=1, inputs randomised after capture -> 39 consecutive words starting next cycle: 16'hA55A, 16'h0001, 1..16, 16'h0100..16'h010F, 5, 6, 7, 8, checksum 16'hB675 with out_last=1; snap_count=1.
REQ-033 Same stimulus, out_ready pseudo-random 50% -> identical word sequence; out_data stable across every stalled cycle.
REQ-034 snap_req pulsed at stream word 10 -> overrun=1, snap_count stays 1, exactly 39 words, one out_last.
REQ-035 end_program rises in the same cycle as snap_req, then held high 100 cycles -> one stream only, seq word 16'h0001, overrun=0.
REQ-036 reset asserted while word 10 is presented -> out_valid=0 next cycle, snap_count=0; new snap_req -> full 39-word stream with seq word 16'h0001.
